mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Sequential front-end controller for the 8:1 channel multiplexer.
- Drives the mux select lines through a masked channel sequence and samples the mux output once per enabled channel, after a programmable settle time.
- Assembles the samples into an 8-bit snapshot word and presents it on a valid/ready interface to downstream logic.
- Supports single-shot and continuous scanning, and abort.

Parameters:
- SETTLE, 1, number of settle cycles between a select change and the sample; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled when a word is accepted.
- abort  input  1  terminate any activity; return to IDLE.
- mask  input  8  channel enable; bit k enables channel k.
- sel  output  3  registered select to the mux s[2:0].
- y_in  input  1  mux output y; combinational from sel.
- busy  output  1  high in every state except IDLE.
- word  output  8  snapshot; bit k = sample of channel k, 0 for masked-off channels.
- word_valid  output  1  snapshot available; held until accepted.
- word_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - sel=0, word=0, word_valid=0, busy=0.
  - mask_q=0, shadow=0, settle counter=0.
  - Reset asserted mid-scan discards everything immediately.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and mask!=0: latch mask into mask_q, clear shadow, set sel to the lowest set bit of mask, load counter=SETTLE.
  - Next state is SETTLE, or SAMPLE if SETTLE=0.
  - start=1 with mask=0: ignored, stay IDLE.
- SETTLE:
  - Counter decrements each cycle.
  - Leave to SAMPLE after exactly SETTLE cycles in SETTLE.
  - sel is stable throughout.
- SAMPLE (exactly one cycle):
  - shadow[sel] <= y_in.
  - If mask_q has a set bit above sel: sel <= next higher set bit, reload counter, go to SETTLE (or SAMPLE if SETTLE=0).
  - Otherwise: word <= shadow including this sample, with masked-off bits 0; word_valid <= 1; go to DONE.
  - Channels are scanned in ascending index order only; there is no wrap within a scan.
- DONE:
  - word_valid stays 1 and word stays stable until word_ready=1.
  - On an accepting edge, word_valid <= 0.
  - If cont=1 and current mask!=0: restart as from IDLE with the new mask latched (no idle cycle).
  - Otherwise: go to IDLE, sel <= 0.
- Timing:
  - Each enabled channel costs SETTLE+1 cycles.
  - With start sampled at edge E and N enabled channels, word_valid rises at edge E + N*(SETTLE+1).
  - Channel k is sampled at its SAMPLE-state edge.
- abort:
  - Takes effect from any state at the next edge: state=IDLE, sel=0, word_valid=0.
  - word keeps its last value.
  - Priority: abort > word_ready/cont restart > start.
- Other rules:
  - start while busy is ignored.
  - word_ready while word_valid=0 is ignored.
  - mask changes during a scan have no effect; only mask_q is used.
  - word is updated only on scan completion, never partially.
  - word_valid is never asserted without word holding a complete scan.

Test Plan:
- Reset: hold rst_n=0 mid-scan, assert asynchronously between edges -> sel=0, word=0, word_valid=0, busy=0 immediately.
- Full scan: SETTLE=1, mask=8'hFF, y_in driven by a model mux with inputs 8'hA5 -> sel steps 0..7 every 2 cycles; word_valid rises at E+16; word=8'hA5; word_ready=1 -> valid drops; IDLE, busy=0.
- Sparse mask: SETTLE=0, mask=8'h81, inputs 8'hFF -> sel visits 0 then 7 only; word_valid at E+2; word=8'h81.
- Backpressure and continuous mode:
  - cont=1, word_ready=0 for 10 cycles -> word and valid stable, sel frozen, no resample.
  - Then word_ready=1 with inputs changed to 8'h3C, mask=FF -> next word=8'h3C, valid at accept edge + 16 (SETTLE=1).
- Abort: assert abort during channel 4 SETTLE, and separately together with word_ready in DONE (cont=1) -> IDLE next edge, word_valid=0, word unchanged, no restart.
- Ignored starts: start with mask=0 -> stays IDLE, busy=0; start pulses during a scan -> scan timing and result unchanged.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side signals of the channel scan controller.
// master = scan controller, slave = environment (mux, host, downstream consumer).
interface mux_scan_ctrl_if;
    logic       start;
    logic       cont;
    logic       abort;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       y_in;
    logic       busy;
    logic [7:0] word;
    logic       word_valid;
    logic       word_ready;

    modport master (
        input  start, cont, abort, mask, y_in, word_ready,
        output sel, busy, word, word_valid
    );

    modport slave (
        output start, cont, abort, mask, y_in, word_ready,
        input  sel, busy, word, word_valid
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux through the enabled channels in ascending order, samples each
// after SETTLE cycles, and hands the assembled snapshot downstream over valid/ready.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no scan in progress, sel parked at 0
// ST_SETTLE | sel applied, waiting for the mux output to settle
// ST_SAMPLE | one cycle: capture y_in into the shadow bit of the current channel
// ST_DONE   | snapshot presented, waiting for word_ready
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
    // With no settle time the first cycle after a select change is already the sample.
    localparam state_t     ST_FIRST  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t     state, state_nx;
    logic [2:0] sel_q, sel_nx;
    logic [3:0] cnt_q, cnt_nx;
    logic [7:0] mask_q, mask_nx;
    logic [7:0] shadow_q, shadow_nx;
    logic [7:0] word_q, word_nx;
    logic       valid_q, valid_nx;
    logic [7:0] above;
    logic       launch;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_q    <= 3'd0;
            cnt_q    <= 4'd0;
            mask_q   <= 8'd0;
            shadow_q <= 8'd0;
            word_q   <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            sel_q    <= sel_nx;
            cnt_q    <= cnt_nx;
            mask_q   <= mask_nx;
            shadow_q <= shadow_nx;
            word_q   <= word_nx;
            valid_q  <= valid_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sel_nx    = sel_q;
        cnt_nx    = cnt_q;
        mask_nx   = mask_q;
        shadow_nx = shadow_q;
        word_nx   = word_q;
        valid_nx  = valid_q;
        launch    = 1'b0;
        above     = mask_q & (8'hFE << sel_q);

        case (state)
            ST_IDLE: begin
                launch = bus.start && (bus.mask != 8'd0);
            end
            ST_SETTLE: begin
                if (cnt_q <= 4'd1) begin
                    cnt_nx   = 4'd0;
                    state_nx = ST_SAMPLE;
                end else begin
                    cnt_nx = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                shadow_nx[sel_q] = bus.y_in;
                if (above != 8'd0) begin
                    sel_nx   = lowest_bit(above);
                    cnt_nx   = SETTLE_LD;
                    state_nx = ST_FIRST;
                end else begin
                    word_nx  = shadow_nx & mask_q;
                    valid_nx = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.word_ready) begin
                    valid_nx = 1'b0;
                    if (bus.cont && (bus.mask != 8'd0)) begin
                        launch = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                        sel_nx   = 3'd0;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (launch && !bus.abort) begin
            mask_nx   = bus.mask;
            shadow_nx = 8'd0;
            sel_nx    = lowest_bit(bus.mask);
            cnt_nx    = SETTLE_LD;
            state_nx  = ST_FIRST;
        end

        // Abort leaves word untouched so the last completed snapshot stays readable.
        if (bus.abort) begin
            state_nx = ST_IDLE;
            sel_nx   = 3'd0;
            valid_nx = 1'b0;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
endmodule
